// File: rtl/pipe_instr_issue_if.sv
// ============================================================================
// Module      : pipe_instr_issue_if
// Description : Host/pipeline signal bundle for the instruction issue unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_instr_issue_if #(
  parameter int AW = 5
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          pause;
  logic [31:0]   InstrOut;
  logic          WriteEnable;
  logic          busy;
  logic          done;
  logic [AW:0]   issued_cnt;
  logic [7:0]    stall_cnt;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, start, pause,
    input  InstrOut, WriteEnable, busy, done, issued_cnt, stall_cnt
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, start, pause,
    output InstrOut, WriteEnable, busy, done, issued_cnt, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/pipe_instr_issue.sv
// ============================================================================
// Module      : pipe_instr_issue
// Description : Issues a host-loaded program into the pipeline, one word per
//               clock. Define PIPE_ISSUE_HAZARD_EN to insert RAW-hazard bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_instr_issue #(
  parameter int AW         = 5,
  parameter int HAZ_WINDOW = 3
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pipe_instr_issue_if.slave bus
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] mem_q [DEPTH];
  logic [AW:0] pc_q, len_q, issued_q;
  logic [31:0] instr_q;
  logic        we_q, busy_q, done_q;
  logic [31:0] fetch_w;
  logic        start_w;
  logic        hazard_w;
  logic [7:0]  stall_w;

  assign fetch_w = mem_q[pc_q[AW-1:0]];
  assign start_w = (state_q != S_RUN) && bus.start;

  // Program store has no reset; writes are locked out while a run is active.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (state_q != S_RUN))
      mem_q[bus.prog_addr] <= bus.prog_data;
  end

`ifdef PIPE_ISSUE_HAZARD_EN
  logic       hv_q  [HAZ_WINDOW];
  logic [4:0] hrd_q [HAZ_WINDOW];
  logic [7:0] stall_q;
  logic       is_r_w;
  logic       slot_issue_w;

  assign is_r_w = (fetch_w[31:28] == 4'b0100);

  always_comb begin
    hazard_w = 1'b0;
    for (int i = 0; i < HAZ_WINDOW; i++) begin
      if (hv_q[i] && ((hrd_q[i] == fetch_w[20:16]) ||
                      (is_r_w && (hrd_q[i] == fetch_w[15:11]))))
        hazard_w = 1'b1;
    end
  end

  assign slot_issue_w = !bus.pause && (pc_q != len_q) && !hazard_w;

  // Slot 0 is the most recent issue slot; bubbles shift in as invalid entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HAZ_WINDOW; i++) begin
        hv_q[i]  <= 1'b0;
        hrd_q[i] <= 5'd0;
      end
      stall_q <= 8'd0;
    end else if (start_w) begin
      for (int i = 1; i < HAZ_WINDOW; i++) begin
        hv_q[i]  <= 1'b0;
        hrd_q[i] <= 5'd0;
      end
      hv_q[0]  <= (bus.prog_len != '0);
      hrd_q[0] <= mem_q[0][25:21];
      stall_q  <= 8'd0;
    end else if (state_q == S_RUN) begin
      for (int i = HAZ_WINDOW - 1; i > 0; i--) begin
        hv_q[i]  <= hv_q[i-1];
        hrd_q[i] <= hrd_q[i-1];
      end
      hv_q[0]  <= slot_issue_w;
      hrd_q[0] <= fetch_w[25:21];
      if (!bus.pause && (pc_q != len_q) && hazard_w && (stall_q != 8'hFF))
        stall_q <= stall_q + 8'd1;
    end
  end

  assign stall_w = stall_q;
`else
  assign hazard_w = 1'b0;
  assign stall_w  = 8'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      issued_q <= '0;
      instr_q  <= 32'd0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          instr_q <= 32'd0;
          we_q    <= 1'b0;
          if (bus.start) begin
            len_q    <= bus.prog_len;
            issued_q <= '0;
            pc_q     <= '0;
            done_q   <= 1'b0;
            if (bus.prog_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q  <= S_RUN;
              busy_q   <= 1'b1;
              instr_q  <= mem_q[0];
              we_q     <= 1'b1;
              pc_q     <= LEN_ONE;
              issued_q <= LEN_ONE;
            end
          end
        end
        S_RUN: begin
          if (bus.pause || hazard_w && (pc_q != len_q)) begin
            instr_q <= 32'd0;
            we_q    <= 1'b0;
          end else if (pc_q == len_q) begin
            instr_q <= 32'd0;
            we_q    <= 1'b0;
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            instr_q  <= fetch_w;
            we_q     <= 1'b1;
            pc_q     <= pc_q + LEN_ONE;
            issued_q <= issued_q + LEN_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.InstrOut    = instr_q;
  assign bus.WriteEnable = we_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.issued_cnt  = issued_q;
  assign bus.stall_cnt   = stall_w;
endmodule

`default_nettype wire
